// File: rtl/metro_mpi_pkg.sv
// metro_mpi_pkg: shared flit type, sender FSM state encoding and the
// default credit constants used by the metro-mpi link blocks.
package metro_mpi_pkg;

    localparam int FLIT_W = 64;

    // Credits the receiver grants out of reset and the sender's ceiling.
    localparam int DEF_INIT_CREDITS = 1;
    localparam int DEF_MAX_CREDITS  = 4;

    // Width of the statistics counters.
    localparam int STAT_W = 32;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_RUN  = 2'd1,
        S_ERR  = 2'd2
    } sender_state_e;

endpackage

// File: rtl/mpi_sync_fifo.sv
// mpi_sync_fifo: single-clock FIFO with push/pop, occupancy count and
// full/empty flags. The head entry is visible combinationally on rdata_o,
// so a flit written at one edge can be popped at the very next edge.
// Reset is synchronous and active-low; storage itself is not cleared.
module mpi_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic push_ok;
    logic pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem[rd_ptr_q];

    // Overfilling or underflowing is refused here regardless of the caller.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Next pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write port.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/sender_mpi.sv
// sender_mpi: credit-based transmit stage feeding the metro-mpi receiver.
// Buffers producer flits and sends at most one per cycle, only while a
// credit is held. Each yummy returns a credit; a yummy arriving at the
// credit ceiling without a matching send is an overflow, which is latched
// on err_o and stops transmission until reset.
// Optional statistics counters are built when SENDER_MPI_STATS_EN is defined.
module sender_mpi
    import metro_mpi_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int INIT_CREDITS = DEF_INIT_CREDITS,
    parameter int MAX_CREDITS  = DEF_MAX_CREDITS
) (
    input  logic                               clk_i,
    input  logic                               rstn_i,
    input  logic                               valid_i,
    input  logic [63:0]                        data_i,
    output logic                               ready_o,
    output logic                               valid_o,
    output logic [63:0]                        data_o,
    input  logic                               yummy_i,
    output logic [$clog2(MAX_CREDITS+1)-1:0]   credit_o,
    output logic                               err_o,
    output logic [31:0]                        sent_cnt_o,
    output logic [31:0]                        stall_cnt_o
);

    localparam int CREDIT_W = $clog2(MAX_CREDITS+1);
    localparam int FCNT_W   = $clog2(FIFO_DEPTH+1);

    sender_state_e state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                err_q, err_d;
    logic                valid_q, valid_d;
    flit_t               data_q, data_d;

    flit_t             fifo_head;
    logic [FCNT_W-1:0] fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;

    logic send;
    logic overflow;

    // Ready comes from the registered occupancy, so a pop at a full FIFO
    // only frees a slot from the following cycle. Held low during reset.
    assign ready_o   = rstn_i && (fifo_count < FCNT_W'(FIFO_DEPTH));
    assign fifo_push = valid_i && ready_o && !fifo_full;

    mpi_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FLIT_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (fifo_push),
        .wdata_i (data_i),
        .pop_i   (send),
        .rdata_o (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign send     = (state_q == S_RUN) && !fifo_empty && (credit_q != '0);
    assign overflow = (credit_q == CREDIT_W'(MAX_CREDITS)) && yummy_i && !send;

    // Credit accounting, FSM next state and the registered link outputs.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        valid_d = send;
        data_d  = send ? fifo_head : data_q;

        // Credits are tracked in every state; an overflow saturates.
        if (overflow) begin
            credit_d = credit_q;
        end else begin
            credit_d = credit_q - CREDIT_W'(send) + CREDIT_W'(yummy_i);
        end

        unique case (state_q)
            S_INIT: state_d = S_RUN;
            S_RUN: begin
                if (overflow) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end
            end
            S_ERR:   state_d = S_ERR;
            default: state_d = S_ERR;
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q  <= S_INIT;
            credit_q <= CREDIT_W'(INIT_CREDITS);
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
        end
    end

    assign credit_o = credit_q;
    assign err_o    = err_q;
    assign valid_o  = valid_q;
    assign data_o   = data_q;

`ifdef SENDER_MPI_STATS_EN
    logic [STAT_W-1:0] sent_cnt_q, sent_cnt_d;
    logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic              stall;

    assign stall = (state_q == S_RUN) && !fifo_empty && (credit_q == '0);

    // Saturating counts of sends and of credit-starved cycles.
    always_comb begin
        sent_cnt_d  = sent_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (send && (sent_cnt_q != '1)) begin
            sent_cnt_d = sent_cnt_q + 1'b1;
        end
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            sent_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            sent_cnt_q  <= sent_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign sent_cnt_o  = sent_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`else
    assign sent_cnt_o  = '0;
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_sender_mpi.sv
// tb_sender_mpi: directed scenarios for sender_mpi with hand-computed
// expectations. Inputs change and outputs are sampled 1 ns after each
// rising edge.
module tb_sender_mpi;

`ifdef SENDER_MPI_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn_i;
    logic        valid_i;
    logic [63:0] data_i;
    logic        ready_o;
    logic        valid_o;
    logic [63:0] data_o;
    logic        yummy_i;
    logic [2:0]  credit_o;
    logic        err_o;
    logic [31:0] sent_cnt_o;
    logic [31:0] stall_cnt_o;

    int errors = 0;
    int checks = 0;

    sender_mpi #(
        .FIFO_DEPTH   (4),
        .INIT_CREDITS (1),
        .MAX_CREDITS  (4)
    ) dut (
        .clk_i       (clk),
        .rstn_i      (rstn_i),
        .valid_i     (valid_i),
        .data_i      (data_i),
        .ready_o     (ready_o),
        .valid_o     (valid_o),
        .data_o      (data_o),
        .yummy_i     (yummy_i),
        .credit_o    (credit_o),
        .err_o       (err_o),
        .sent_cnt_o  (sent_cnt_o),
        .stall_cnt_o (stall_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn_i = 1'b0; valid_i = 1'b0; data_i = '0; yummy_i = 1'b0;
        step(); step();
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", ready_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", valid_o); end
        checks++; if (data_o !== 64'd0) begin errors++; $display("FAIL rst_data got=%h exp=0", data_o); end
        checks++; if (credit_o !== 3'd1) begin errors++; $display("FAIL rst_credit got=%0d exp=1", credit_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", err_o); end
        checks++; if (sent_cnt_o !== 32'd0) begin errors++; $display("FAIL rst_sent got=%0d exp=0", sent_cnt_o); end
        checks++; if (stall_cnt_o !== 32'd0) begin errors++; $display("FAIL rst_stall got=%0d exp=0", stall_cnt_o); end
        rstn_i = 1'b1;
        #1;
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL init_ready got=%b exp=1", ready_o); end
        $display("reset: done");
    endtask

    // Starts in the S_INIT cycle; one credit, three flits pushed.
    task automatic test_credit_gating();
        valid_i = 1'b1; data_i = 64'hA1;
        step();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL gate_v0 got=%b exp=0", valid_o); end
        data_i = 64'hA2;
        step();
        checks++; if (valid_o !== 1'b1 || data_o !== 64'hA1) begin errors++; $display("FAIL gate_a1 got=%b/%h exp=1/a1", valid_o, data_o); end
        checks++; if (credit_o !== 3'd0) begin errors++; $display("FAIL gate_credit got=%0d exp=0", credit_o); end
        data_i = 64'hA3;
        step();
        checks++; if (valid_o !== 1'b0 || data_o !== 64'hA1) begin errors++; $display("FAIL gate_hold got=%b/%h exp=0/a1", valid_o, data_o); end
        valid_i = 1'b0;
        step();
        checks++; if (valid_o !== 1'b0 || credit_o !== 3'd0) begin errors++; $display("FAIL gate_starved got=%b/%0d exp=0/0", valid_o, credit_o); end
        checks++; if (stall_cnt_o !== (STATS ? 32'd2 : 32'd0)) begin errors++; $display("FAIL gate_stall got=%0d exp=%0d", stall_cnt_o, STATS ? 2 : 0); end
        $display("credit_gating: A1 sent, A2/A3 buffered");
    endtask

    task automatic test_credit_restore();
        yummy_i = 1'b1;
        step();
        checks++; if (credit_o !== 3'd1 || valid_o !== 1'b0) begin errors++; $display("FAIL rest_c1 got=%0d/%b exp=1/0", credit_o, valid_o); end
        step();
        checks++; if (valid_o !== 1'b1 || data_o !== 64'hA2 || credit_o !== 3'd1) begin errors++; $display("FAIL rest_a2 got=%b/%h/%0d exp=1/a2/1", valid_o, data_o, credit_o); end
        yummy_i = 1'b0;
        step();
        checks++; if (valid_o !== 1'b1 || data_o !== 64'hA3 || credit_o !== 3'd0) begin errors++; $display("FAIL rest_a3 got=%b/%h/%0d exp=1/a3/0", valid_o, data_o, credit_o); end
        step();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rest_idle got=%b exp=0", valid_o); end
        checks++; if (sent_cnt_o !== (STATS ? 32'd3 : 32'd0)) begin errors++; $display("FAIL rest_sent got=%0d exp=%0d", sent_cnt_o, STATS ? 3 : 0); end
        checks++; if (stall_cnt_o !== (STATS ? 32'd3 : 32'd0)) begin errors++; $display("FAIL rest_stall got=%0d exp=%0d", stall_cnt_o, STATS ? 3 : 0); end
        $display("credit_restore: A2 A3 sent");
    endtask

    task automatic test_full_fifo();
        logic [63:0] b [5];
        for (int i = 0; i < 5; i++) b[i] = 64'hB0 + 64'(i);
        for (int i = 0; i < 4; i++) begin
            valid_i = 1'b1; data_i = b[i];
            checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL full_ready%0d got=%b exp=1", i, ready_o); end
            step();
        end
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL full_drop got=%b exp=0", ready_o); end
        data_i = b[4];
        step();
        checks++; if (ready_o !== 1'b0 || valid_o !== 1'b0) begin errors++; $display("FAIL full_held got=%b/%b exp=0/0", ready_o, valid_o); end
        yummy_i = 1'b1;
        step();
        checks++; if (credit_o !== 3'd1 || ready_o !== 1'b0) begin errors++; $display("FAIL full_yummy got=%0d/%b exp=1/0", credit_o, ready_o); end
        yummy_i = 1'b0;
        step();
        checks++; if (valid_o !== 1'b1 || data_o !== b[0] || ready_o !== 1'b1) begin errors++; $display("FAIL full_send got=%b/%h/%b exp=1/%h/1", valid_o, data_o, ready_o, b[0]); end
        step();
        checks++; if (ready_o !== 1'b0 || valid_o !== 1'b0) begin errors++; $display("FAIL full_refill got=%b/%b exp=0/0", ready_o, valid_o); end
        valid_i = 1'b0;
        checks++; if (sent_cnt_o !== (STATS ? 32'd4 : 32'd0)) begin errors++; $display("FAIL full_sent got=%0d exp=%0d", sent_cnt_o, STATS ? 4 : 0); end
        $display("full_fifo: B4 held off, one send frees one slot");
    endtask

    task automatic test_simultaneous();
        yummy_i = 1'b1;
        step();
        checks++; if (credit_o !== 3'd1 || valid_o !== 1'b0) begin errors++; $display("FAIL sim_c1 got=%0d/%b exp=1/0", credit_o, valid_o); end
        step();
        checks++; if (valid_o !== 1'b1 || data_o !== 64'hB1 || credit_o !== 3'd1) begin errors++; $display("FAIL sim_send got=%b/%h/%0d exp=1/b1/1", valid_o, data_o, credit_o); end
        yummy_i = 1'b0;
        rstn_i = 1'b0;
        step();
        rstn_i = 1'b1;
        yummy_i = 1'b1;
        step(); step(); step();
        yummy_i = 1'b0;
        checks++; if (credit_o !== 3'd4 || err_o !== 1'b0) begin errors++; $display("FAIL sim_max got=%0d/%b exp=4/0", credit_o, err_o); end
        valid_i = 1'b1; data_i = 64'hC1;
        step();
        valid_i = 1'b0; yummy_i = 1'b1;
        step();
        yummy_i = 1'b0;
        checks++; if (valid_o !== 1'b1 || data_o !== 64'hC1 || credit_o !== 3'd4 || err_o !== 1'b0) begin errors++; $display("FAIL sim_atmax got=%b/%h/%0d/%b exp=1/c1/4/0", valid_o, data_o, credit_o, err_o); end
        step();
        $display("simultaneous: send+yummy keeps credit");
    endtask

    task automatic test_overflow();
        yummy_i = 1'b1;
        step();
        yummy_i = 1'b0;
        checks++; if (err_o !== 1'b1 || credit_o !== 3'd4) begin errors++; $display("FAIL ovf_set got=%b/%0d exp=1/4", err_o, credit_o); end
        valid_i = 1'b1; data_i = 64'hD1;
        step();
        data_i = 64'hD2;
        step();
        valid_i = 1'b0;
        checks++; if (valid_o !== 1'b0 || err_o !== 1'b1) begin errors++; $display("FAIL ovf_nosend1 got=%b/%b exp=0/1", valid_o, err_o); end
        step(); step();
        checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1 || credit_o !== 3'd4) begin errors++; $display("FAIL ovf_nosend2 got=%b/%b/%0d exp=0/1/4", valid_o, ready_o, credit_o); end
        $display("overflow: err latched, D1/D2 buffered");
    endtask

    task automatic test_reset_mid();
        rstn_i = 1'b0;
        #1;
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL mid_ready got=%b exp=0", ready_o); end
        step();
        checks++; if (valid_o !== 1'b0 || credit_o !== 3'd1 || err_o !== 1'b0) begin errors++; $display("FAIL mid_state got=%b/%0d/%b exp=0/1/0", valid_o, credit_o, err_o); end
        rstn_i = 1'b1; valid_i = 1'b1; data_i = 64'hE1;
        step();
        valid_i = 1'b0;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL mid_v0 got=%b exp=0", valid_o); end
        step();
        checks++; if (valid_o !== 1'b1 || data_o !== 64'hE1) begin errors++; $display("FAIL mid_e1 got=%b/%h exp=1/e1", valid_o, data_o); end
        yummy_i = 1'b1;
        step();
        yummy_i = 1'b0;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL mid_empty got=%b exp=0", valid_o); end
        $display("reset_mid: FIFO flushed, E1 sent");
    endtask

    initial begin
        test_reset();
        test_credit_gating();
        test_credit_restore();
        test_full_fifo();
        test_simultaneous();
        test_overflow();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
